// File: rtl/lsp_prev_compose.sv
// MA-predicted LSP composition: lsp[j] = extract_h(L_mult(lsp_ele[j], fg_sum[j]) + sum_k fg[k][j]*freq_prev[k][j]).
// Drives the shared scratch memory, constant ROM and basic-op units. Holds no arithmetic of its own.
module lsp_prev_compose #(
  parameter int M     = 10,
  parameter int MA_NP = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [10:0] lsp_eleAddr,
  input  logic [10:0] freq_prevAddr,
  input  logic [10:0] lspAddr,
  input  logic [10:0] fgAddr,
  input  logic [10:0] fg_sumAddr,
  input  logic [31:0] memIn,
  input  logic [31:0] constMemIn,
  input  logic [31:0] L_multIn,
  input  logic [31:0] L_macIn,
  input  logic [15:0] addIn,
  output logic [10:0] memReadAddr,
  output logic [10:0] constMemAddr,
  output logic [10:0] memWriteAddr,
  output logic [31:0] memOut,
  output logic        memWriteEn,
  output logic [15:0] L_multOutA,
  output logic [15:0] L_multOutB,
  output logic [31:0] L_macOutA,
  output logic [15:0] L_macOutB,
  output logic [15:0] L_macOutC,
  output logic [15:0] addOutA,
  output logic [15:0] addOutB,
  output logic        done
);

  typedef enum logic [2:0] {
    INIT, J_CHECK, ELE_RD, ELE_MULT, K_CHECK, PREV_RD, PREV_MAC, STORE
  } state_t;

  state_t      state;
  logic [3:0]  j;
  logic [2:0]  k;
  logic [31:0] L_acc;
  logic [10:0] j_ext;

  assign j_ext = {7'd0, j};

  // Only the low halves of the read buses and adder result carry meaning here.
  logic unused_bits;
  assign unused_bits = ^{memIn[31:16], constMemIn[31:16], addIn[15:4],
                         freq_prevAddr[5:0], fgAddr[5:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= INIT;
      j     <= 4'd0;
      k     <= 3'd0;
      L_acc <= 32'd0;
    end else begin
      case (state)
        INIT: begin
          if (start) begin
            j     <= 4'd0;
            k     <= 3'd0;
            L_acc <= 32'd0;
            state <= J_CHECK;
          end
        end
        J_CHECK:  state <= (j == 4'(M)) ? INIT : ELE_RD;
        ELE_RD:   state <= ELE_MULT;
        ELE_MULT: begin
          L_acc <= L_multIn;
          k     <= 3'd0;
          state <= K_CHECK;
        end
        K_CHECK:  state <= (k == 3'(MA_NP)) ? STORE : PREV_RD;
        PREV_RD:  state <= PREV_MAC;
        PREV_MAC: begin
          L_acc <= L_macIn;
          k     <= addIn[2:0];
          state <= K_CHECK;
        end
        STORE: begin
          j     <= addIn[3:0];
          state <= J_CHECK;
        end
        default:  state <= INIT;
      endcase
    end
  end

  // Outputs decode from state alone; they are forced quiet while reset is asserted.
  always_comb begin
    memReadAddr  = 11'd0;
    constMemAddr = 11'd0;
    memWriteAddr = 11'd0;
    memOut       = 32'd0;
    memWriteEn   = 1'b0;
    L_multOutA   = 16'd0;
    L_multOutB   = 16'd0;
    L_macOutA    = 32'd0;
    L_macOutB    = 16'd0;
    L_macOutC    = 16'd0;
    addOutA      = 16'd0;
    addOutB      = 16'd0;
    done         = 1'b0;
    if (!reset) begin
      case (state)
        J_CHECK: done = (j == 4'(M));
        ELE_RD: begin
          memReadAddr  = lsp_eleAddr + j_ext;
          constMemAddr = fg_sumAddr + j_ext;
        end
        ELE_MULT: begin
          L_multOutA = memIn[15:0];
          L_multOutB = constMemIn[15:0];
        end
        PREV_RD: begin
          memReadAddr  = {freq_prevAddr[10:6], k[1:0], 4'd0} + j_ext;
          constMemAddr = {fgAddr[10:6], k[1:0], j};
        end
        PREV_MAC: begin
          L_macOutA = L_acc;
          L_macOutB = memIn[15:0];
          L_macOutC = constMemIn[15:0];
          addOutA   = {13'd0, k};
          addOutB   = 16'd1;
        end
        STORE: begin
          memWriteAddr = lspAddr + j_ext;
          memOut       = {{16{L_acc[31]}}, L_acc[31:16]};
          memWriteEn   = 1'b1;
          addOutA      = {12'd0, j};
          addOutB      = 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsp_prev_compose.sv
// Bench for lsp_prev_compose: models scratch/ROM and the shared basic-op units,
// and checks each run against a saturating fixed-point reference of the predictor sum.
module tb_lsp_prev_compose;

  localparam logic [10:0] ELE_BASE = 11'h100;
  localparam logic [10:0] LSP_BASE = 11'h200;
  localparam logic [10:0] FP_BASE  = 11'h400;
  localparam logic [10:0] FG_BASE  = 11'h080;
  localparam logic [10:0] FGS_BASE = 11'h300;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [10:0] lspBase;
  logic [31:0] memIn, constMemIn, lMultIn, lMacIn;
  logic [15:0] addIn;
  logic [10:0] memReadAddr, constMemAddr, memWriteAddr;
  logic [31:0] memOut, lMacOutA;
  logic        memWriteEn, done;
  logic [15:0] lMultOutA, lMultOutB, lMacOutB, lMacOutC, addOutA, addOutB;

  logic [31:0] scratch [2048];
  logic [31:0] rom     [2048];
  logic [15:0] ele [10];
  logic [15:0] fgs [10];
  logic [15:0] fp  [4][10];
  logic [15:0] fgm [4][10];

  int checkCount = 0;
  int passCount  = 0;
  int writeCount = 0;
  int badWrites  = 0;

  lsp_prev_compose dut (
    .clk(clk), .reset(reset), .start(start),
    .lsp_eleAddr(ELE_BASE), .freq_prevAddr(FP_BASE), .lspAddr(lspBase),
    .fgAddr(FG_BASE), .fg_sumAddr(FGS_BASE),
    .memIn(memIn), .constMemIn(constMemIn), .L_multIn(lMultIn), .L_macIn(lMacIn), .addIn(addIn),
    .memReadAddr(memReadAddr), .constMemAddr(constMemAddr), .memWriteAddr(memWriteAddr),
    .memOut(memOut), .memWriteEn(memWriteEn),
    .L_multOutA(lMultOutA), .L_multOutB(lMultOutB),
    .L_macOutA(lMacOutA), .L_macOutB(lMacOutB), .L_macOutC(lMacOutC),
    .addOutA(addOutA), .addOutB(addOutB), .done(done)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [31:0] sat32(input longint v);
    if (v > 64'sd2147483647) return 32'h7FFF_FFFF;
    if (v < -64'sd2147483648) return 32'h8000_0000;
    return v[31:0];
  endfunction

  function automatic logic [31:0] lmult(input logic [15:0] a, input logic [15:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b)) * 2;
    return sat32(p);
  endfunction

  function automatic logic [31:0] lmac(input logic [31:0] acc, input logic [15:0] a, input logic [15:0] b);
    return sat32(longint'($signed(acc)) + longint'($signed(lmult(a, b))));
  endfunction

  // Shared arithmetic units and the two 1-cycle-latency memories seen by the DUT
  assign lMultIn = lmult(lMultOutA, lMultOutB);
  assign lMacIn  = lmac(lMacOutA, lMacOutB, lMacOutC);
  assign addIn   = addOutA + addOutB;

  always @(posedge clk) begin
    memIn      <= scratch[memReadAddr];
    constMemIn <= rom[constMemAddr];
    if (memWriteEn) begin
      scratch[memWriteAddr] <= memOut;
      writeCount <= writeCount + 1;
      if (memWriteAddr < lspBase || memWriteAddr >= lspBase + 11'd10) badWrites <= badWrites + 1;
    end
  end

  // Reference: saturating accumulation of the base product and four predictor taps, then high half.
  function automatic logic [31:0] expectedWord(input int j);
    logic [31:0] acc;
    logic [15:0] h;
    acc = lmult(ele[j], fgs[j]);
    for (int k = 0; k < 4; k++)
      acc = sat32(longint'($signed(acc)) + longint'($signed(lmult(fp[k][j], fgm[k][j]))));
    h = acc[31:16];
    return {{16{h[15]}}, h};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic applyStimulus(input int mode);
    logic [31:0] r;
    for (int j = 0; j < 10; j++) begin
      ele[j] = 16'($urandom);
      fgs[j] = 16'($urandom);
      for (int k = 0; k < 4; k++) begin
        fp[k][j]  = 16'($urandom);
        fgm[k][j] = 16'($urandom);
      end
    end
    for (int j = 0; j < 10; j++) begin
      case (mode)
        0: begin ele[j] = 16'h4000; fgs[j] = 16'h4000; for (int k = 0; k < 4; k++) fp[k][j] = 16'h0; end
        1: begin
          ele[j] = 16'h4000; fgs[j] = 16'h4000;
          for (int k = 0; k < 4; k++) begin fp[k][j] = 16'h1000; fgm[k][j] = 16'h1000; end
        end
        4: begin ele[j] = 16'(16'h0100 * (j + 1)); fgs[j] = 16'h7FFF; end
        default: ;
      endcase
    end
    if (mode == 2) begin
      ele[0] = 16'h8000; fgs[0] = 16'h8000;
      for (int k = 0; k < 4; k++) begin fp[k][0] = 16'h7FFF; fgm[k][0] = 16'h7FFF; end
    end
    if (mode == 3) begin
      ele[3] = 16'hC000; fgs[3] = 16'h4000;
      for (int k = 0; k < 4; k++) fp[k][3] = 16'h0;
    end
    lspBase = (mode == 4) ? ELE_BASE : LSP_BASE;
    for (int j = 0; j < 10; j++) begin
      r = $urandom; scratch[ELE_BASE + 11'(j)] = {r[31:16], ele[j]};
      r = $urandom; rom[FGS_BASE + 11'(j)]     = {r[31:16], fgs[j]};
      if (mode != 4) begin r = $urandom; scratch[LSP_BASE + 11'(j)] = r; end
      for (int k = 0; k < 4; k++) begin
        r = $urandom; scratch[FP_BASE + 11'(k * 16 + j)] = {r[31:16], fp[k][j]};
        r = $urandom; rom[FG_BASE + 11'(k * 16 + j)]     = {r[31:16], fgm[k][j]};
      end
    end
  endtask

  task automatic checkResults(input string tag);
    for (int j = 0; j < 10; j++)
      checkOutput($sformatf("%s lsp[%0d]", tag, j), scratch[lspBase + 11'(j)], expectedWord(j));
    for (int k = 0; k < 4; k++)
      checkOutput($sformatf("%s freq_prev row %0d kept", tag, k),
                  {16'd0, scratch[FP_BASE + 11'(k * 16 + 3)][15:0]}, {16'd0, fp[k][3]});
  endtask

  // One run from a start pulse; optionally pokes start mid-run, which must be ignored.
  task automatic runOnce(input string tag, input bit glitch);
    int n, w0, b0;
    w0 = writeCount; b0 = badWrites;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    n = 1;
    while (!done && n < 400) begin
      @(negedge clk);
      n++;
      start = (glitch && n == 50);
    end
    start = 1'b0;
    checkOutput({tag, " done cycle"}, n, 171);
    @(negedge clk);
    checkOutput({tag, " done one-shot"}, {31'd0, done}, 32'd0);
    checkOutput({tag, " write count"}, writeCount - w0, 10);
    checkOutput({tag, " stray writes"}, badWrites - b0, 0);
    checkResults(tag);
  endtask

  initial begin
    int n, n2, w1;
    bit sawDone;
    for (int i = 0; i < 2048; i++) begin scratch[i] = $urandom; rom[i] = $urandom; end
    lspBase = LSP_BASE;
    reset = 1'b1; start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("reset done", {31'd0, done}, 32'd0);
    checkOutput("reset writeEn", {31'd0, memWriteEn}, 32'd0);
    checkOutput("reset readAddr", {21'd0, memReadAddr}, 32'd0);
    checkOutput("reset addOutA", {16'd0, addOutA}, 32'd0);

    applyStimulus(0); runOnce("base", 1'b0);
    applyStimulus(1); runOnce("fullmac", 1'b0);
    applyStimulus(2); runOnce("saturate", 1'b1);
    checkOutput("saturate lsp0 value", scratch[LSP_BASE], 32'h0000_7FFF);
    applyStimulus(3); runOnce("negative", 1'b0);
    checkOutput("negative lsp3 word", scratch[LSP_BASE + 11'd3], 32'hFFFF_E000);
    applyStimulus(4); runOnce("inplace", 1'b0);
    for (int t = 0; t < 3; t++) begin
      applyStimulus(5); runOnce($sformatf("random%0d", t), 1'b0);
    end

    // Abort a run with reset, then rerun the same data
    applyStimulus(5);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    n = 1;
    while (n < 60) begin @(negedge clk); n++; end
    reset = 1'b1;
    #1;
    checkOutput("midreset quiet writeEn", {31'd0, memWriteEn}, 32'd0);
    @(negedge clk) reset = 1'b0;
    w1 = writeCount; sawDone = 1'b0;
    repeat (200) begin @(negedge clk); if (done) sawDone = 1'b1; end
    checkOutput("midreset no writes", writeCount - w1, 0);
    checkOutput("midreset no done", {31'd0, sawDone}, 32'd0);
    runOnce("rerun", 1'b0);

    // start held high across done restarts immediately
    applyStimulus(5);
    @(negedge clk) start = 1'b1;
    n = 0;
    while (!done && n < 400) begin @(negedge clk); n++; end
    checkOutput("held first done", n, 171);
    n2 = 0;
    @(negedge clk); n2++;
    while (!done && n2 < 400) begin @(negedge clk); n2++; end
    start = 1'b0;
    checkOutput("held second done gap", n2, 172);
    @(negedge clk);
    checkResults("held");

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
